// File: rtl/tdm_demux_4x1_if.sv
// tdm_demux_4x1_if: bundles the serial receive side and the recovered
// parallel frame side of the 1-to-4 TDM demultiplexer.
//   din, din_vld, fsync : serial bit, beat qualifier, frame-start marker
//   sel                 : slot the next accepted beat belongs to
//   lanes               : last complete frame, slot 0 in the low W bits
//   out_vld, frame_err  : single-cycle pulses (new frame / framing error)
//   locked              : high while frame alignment is held
// master drives the serial stream, slave is the demultiplexer.
interface tdm_demux_4x1_if #(
  parameter int W = 8
);
  logic           din;
  logic           din_vld;
  logic           fsync;
  logic [1:0]     sel;
  logic [4*W-1:0] lanes;
  logic           out_vld;
  logic           locked;
  logic           frame_err;

  modport master (
    output din, din_vld, fsync,
    input  sel, lanes, out_vld, locked, frame_err
  );

  modport slave (
    input  din, din_vld, fsync,
    output sel, lanes, out_vld, locked, frame_err
  );
endinterface

// File: rtl/tdm_demux_4x1.sv
// tdm_demux_4x1: receive-side 1-to-4 time-division demultiplexer.
// Rebuilds four W-bit lane words from a serial stream sent slot 0..3,
// MSB first, with fsync on the first bit of each frame. Slot timing is
// recovered by bit/slot counters; framing violations pulse frame_err.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : tdm_demux_4x1_if.slave (din/din_vld/fsync in; sel/lanes/
//          out_vld/locked/frame_err out, all driven from registers)
module tdm_demux_4x1 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux_4x1_if.slave bus
);
  localparam int BW = $clog2(W);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]     slot_cnt_q, slot_cnt_d;
  logic [4*W-1:0] shift_q, shift_d;
  logic [4*W-1:0] lanes_q, lanes_d;
  logic           out_vld_q, out_vld_d;
  logic           frame_err_q, frame_err_d;
  logic [4*W-1:0] frame_s;
  logic           at_start_s;

  // The first bit received lands at the top of the shift register, so
  // slot 0 sits in the upper W bits and must be moved to lanes[W-1:0].
  function automatic logic [4*W-1:0] slot_order(input logic [4*W-1:0] f);
    logic [4*W-1:0] r;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      r[s*W +: W] = f[(3-s)*W +: W];
    end
    return r;
  endfunction

  // State register: FSM state, counters, shift register and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      slot_cnt_q  <= 2'd0;
      shift_q     <= '0;
      lanes_q     <= '0;
      out_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      shift_q     <= shift_d;
      lanes_q     <= lanes_d;
      out_vld_q   <= out_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: framing FSM plus counter and shift-register update.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    shift_d     = shift_q;
    lanes_d     = lanes_q;
    out_vld_d   = 1'b0;
    frame_err_d = 1'b0;
    frame_s     = {shift_q[4*W-2:0], bus.din};
    // In SYNC both counters are zero only on the beat that must open a frame.
    at_start_s  = (bit_cnt_q == '0) && (slot_cnt_q == 2'd0);
    if (bus.din_vld) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            state_d    = SYNC;
            bit_cnt_d  = BW'(1);
            slot_cnt_d = 2'd0;
            shift_d    = {{(4*W-1){1'b0}}, bus.din};
          end else begin
            state_d = HUNT;
          end
        end
        SYNC: begin
          if (at_start_s && !bus.fsync) begin
            // Expected frame start missing: drop the beat and re-hunt.
            frame_err_d = 1'b1;
            state_d     = HUNT;
            bit_cnt_d   = '0;
            slot_cnt_d  = 2'd0;
            shift_d     = '0;
          end else if (bus.fsync) begin
            // Either the expected start or a mid-frame restart; the latter
            // abandons the partial frame but keeps alignment.
            frame_err_d = !at_start_s;
            bit_cnt_d   = BW'(1);
            slot_cnt_d  = 2'd0;
            shift_d     = {{(4*W-1){1'b0}}, bus.din};
          end else begin
            shift_d = frame_s;
            if (bit_cnt_q == BW'(W-1)) begin
              bit_cnt_d  = '0;
              slot_cnt_d = slot_cnt_q + 2'd1;
              if (slot_cnt_q == 2'd3) begin
                lanes_d   = slot_order(frame_s);
                out_vld_d = 1'b1;
              end else begin
                lanes_d = lanes_q;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        default: begin
          state_d    = HUNT;
          bit_cnt_d  = '0;
          slot_cnt_d = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: every output is a register or a decode of the state register.
  always_comb begin
    bus.sel       = slot_cnt_q;
    bus.lanes     = lanes_q;
    bus.out_vld   = out_vld_q;
    bus.frame_err = frame_err_q;
    bus.locked    = (state_q == SYNC);
  end
endmodule

// File: doc/tdm_demux_4x1.md
# tdm_demux_4x1

Receive-side 1-to-4 time-division demultiplexer. It takes a single-bit stream produced by stepping a 4:1 mux select through slots 0..3, and rebuilds the four parallel lane words. Slot timing comes from a frame-sync marker. The block recovers the slot select with internal counters, detects framing errors, and presents each completed frame as one registered, validated 4-lane word.

## Interface
Parameters:
- W, default 8: bits per slot (lane word width), W ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit; valid only when din_vld=1.
- din_vld  input  1  qualifies din/fsync; when low, the cycle is ignored (stall).
- fsync  input  1  marks the first bit of a frame (slot 0, bit W-1); sampled only when din_vld=1.
- sel  output  2  slot currently being received (0..3); this is the recovered mux select.
- lanes  output  4*W  completed frame: lanes[W-1:0] = slot 0 … lanes[4W-1:3W] = slot 3.
- out_vld  output  1  one-cycle pulse when lanes is updated.
- locked  output  1  high while in SYNC state.
- frame_err  output  1  one-cycle pulse on a framing violation.

## Operation
- Frame format: 4 slots × W bits = 4W accepted bits. Slots are sent in order 0,1,2,3, each MSB first. fsync=1 accompanies the first bit only.
- Only cycles with din_vld=1 are "accepted beats". Cycles with din_vld=0 freeze all state and counters, and produce no pulses.
- State machine:
  - HUNT (reset state): beats without fsync are discarded. A beat with fsync=1 → SYNC. That beat is stored as bit 0 of the frame, and bit_cnt=1, slot_cnt=0.
  - SYNC: each beat shifts din into the slot shift register. bit_cnt counts 0..W-1. When bit_cnt wraps from W-1 to 0, slot_cnt increments.
  - On the beat that completes slot 3 (beat 4W of the frame), all four slot words go into lanes, out_vld pulses, and the counters return to 0. The state stays SYNC.
  - Frame boundary check: the next accepted beat must carry fsync=1.
    - If it does, that beat starts the new frame.
    - If it does not, frame_err pulses, the beat is discarded, and the state goes to HUNT.
  - fsync=1 on any beat other than the expected frame start (mid-frame) → frame_err pulses. The partial frame is discarded (lanes unchanged, no out_vld). That beat is taken as bit 0 of a new frame; the state stays SYNC.
- sel = slot_cnt in SYNC, 0 in HUNT. sel always names the slot the next accepted beat belongs to.
- lanes holds the last good frame until the next complete frame. A partial frame never alters lanes.
- Width rules: bit_cnt is ceil(log2 W) bits, slot_cnt is 2 bits. Both wrap without overflow side effects.

## Timing
- Reset (async assert, applied immediately): sel=0, lanes=0, out_vld=0, locked=0, frame_err=0, state=HUNT, counters=0, shift register=0.
- Reset deassertion is sampled synchronously at the next clk edge. A reset asserted mid-frame discards the partial frame, and lanes returns to 0.
- Latency: out_vld and the new lanes appear in the same cycle, one clk after the edge that samples the last bit of slot 3. With din_vld held high that is 4W cycles after the fsync beat.
- out_vld and frame_err are single-cycle registered pulses and are never asserted together.
- locked rises one cycle after the fsync beat is sampled in HUNT. It falls one cycle after the beat that causes the HUNT transition.
- Back-to-back frames with continuous din_vld give out_vld every 4W cycles with no gap.

## Test plan
- Basic frame, W=8, din_vld=1: fsync then lanes 0x01, 0xA5, 0x3C, 0xFF, MSB first → after 32 beats out_vld=1, lanes=0xFF3CA501, locked=1, sel sequence 0→1→2→3→0.
- Stalls: same frame with din_vld low on every third cycle → identical lanes=0xFF3CA501. out_vld comes 48 cycles after fsync; counters and sel frozen in stall cycles.
- Pre-sync garbage: 13 random beats with fsync=0, then a valid frame 0x11,0x22,0x33,0x44 → no out_vld and locked=0 before the fsync beat; then lanes=0x44332211.
- Mid-frame fsync: good frame 0x44332211, then fsync reasserted at beat 20 of the next frame, followed by a full frame 0xDE,0xAD,0xBE,0xEF → frame_err pulse at beat 20, lanes stays 0x44332211, then becomes 0xEFBEADDE, locked stays 1.
- Missing fsync at boundary: after a good frame, the next beat has fsync=0 → frame_err pulse, locked=0, sel=0, lanes unchanged.
- Async reset at beat 17 of a frame, released 3 cycles later → all outputs 0 immediately; a following good frame decodes correctly.
